// File: rtl/ka_pkg.sv
// Shared constants and types for the sequential Karatsuba GF(2) multiplier front end.
package ka_pkg;

    localparam int KA_N = 32;
    localparam int KA_H = KA_N / 2;

    localparam int SLOT_LO  = 0;
    localparam int SLOT_MID = 1;
    localparam int SLOT_HI  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } ka_state_e;

endpackage

// File: rtl/ka_term_collector.sv
// Captures the three in-order sub-products and registers the corrected lo/mid/hi terms.
// With KA_MERGE_OUT_EN defined it also registers the merged (2N-1)-bit product.
module ka_term_collector
    import ka_pkg::*;
#(
    parameter int N = KA_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         cap_en,
    input  logic         rsp_valid,
    input  logic [N-2:0] rsp_data,
    output logic         third_rsp,
    output logic [N-2:0] term_lo,
    output logic [N-2:0] term_mid,
    output logic [N-2:0] term_hi
`ifdef KA_MERGE_OUT_EN
    ,
    output logic [2*N-2:0] product_out
`endif
);

    logic [2:0][N-2:0] slot_q, slot_d;
    logic [1:0]        rsp_cnt_q, rsp_cnt_d;
    logic [N-2:0]      term_lo_q, term_lo_d;
    logic [N-2:0]      term_mid_q, term_mid_d;
    logic [N-2:0]      term_hi_q, term_hi_d;

    always_comb begin
        slot_d    = slot_q;
        rsp_cnt_d = rsp_cnt_q;
        third_rsp = cap_en && rsp_valid && (rsp_cnt_q == 2'(SLOT_HI));
        if (clr) begin
            rsp_cnt_d = '0;
        end else if (cap_en && rsp_valid && (rsp_cnt_q <= 2'(SLOT_HI))) begin
            slot_d[rsp_cnt_q] = rsp_data;
            rsp_cnt_d         = rsp_cnt_q + 2'd1;
        end
    end

    // The hi sub-product is always the last response, so it is taken straight off the bus.
    always_comb begin
        term_lo_d  = term_lo_q;
        term_mid_d = term_mid_q;
        term_hi_d  = term_hi_q;
        if (third_rsp) begin
            term_lo_d  = slot_q[SLOT_LO];
            term_hi_d  = rsp_data;
            term_mid_d = slot_q[SLOT_MID] ^ slot_q[SLOT_LO] ^ rsp_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q     <= '0;
            rsp_cnt_q  <= '0;
            term_lo_q  <= '0;
            term_mid_q <= '0;
            term_hi_q  <= '0;
        end else begin
            slot_q     <= slot_d;
            rsp_cnt_q  <= rsp_cnt_d;
            term_lo_q  <= term_lo_d;
            term_mid_q <= term_mid_d;
            term_hi_q  <= term_hi_d;
        end
    end

    assign term_lo  = term_lo_q;
    assign term_mid = term_mid_q;
    assign term_hi  = term_hi_q;

`ifdef KA_MERGE_OUT_EN
    localparam int H = N / 2;

    logic [2*N-2:0] product_q, product_d;

    always_comb begin
        product_d = {{N{1'b0}}, term_lo_d}
                  ^ {{H{1'b0}}, term_mid_d, {H{1'b0}}}
                  ^ {term_hi_d, {N{1'b0}}};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) product_q <= '0;
        else     product_q <= product_d;
    end

    assign product_out = product_q;
`endif

endmodule

// File: rtl/ka_split_issue_32bit.sv
// Karatsuba front end: splits an operand pair, issues lo/mid/hi half multiplies, returns terms.
// Optional merged product output enabled by defining KA_MERGE_OUT_EN.
module ka_split_issue_32bit
    import ka_pkg::*;
#(
    parameter int N = KA_N
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a_in,
    input  logic [N-1:0]   b_in,
    output logic           sm_req_valid,
    input  logic           sm_req_ready,
    output logic [N/2-1:0] sm_op_a,
    output logic [N/2-1:0] sm_op_b,
    input  logic           sm_rsp_valid,
    input  logic [N-2:0]   sm_rsp_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-2:0]   term_lo,
    output logic [N-2:0]   term_mid,
    output logic [N-2:0]   term_hi
`ifdef KA_MERGE_OUT_EN
    ,
    output logic [2*N-2:0] product_out
`endif
);

    localparam int H = N / 2;

    ka_state_e    state_q, state_d;
    logic [N-1:0] a_q, a_d, b_q, b_d;
    logic [1:0]   req_cnt_q, req_cnt_d;
    logic         accept, req_hs, cap_en, third_rsp;

    assign accept = in_valid && in_ready;
    assign req_hs = sm_req_valid && sm_req_ready;
    assign cap_en = (state_q == ISSUE) || (state_q == WAIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (accept) state_d = ISSUE;
            ISSUE: if (req_hs && (req_cnt_q == 2'(SLOT_HI))) state_d = third_rsp ? DONE : WAIT;
            WAIT:  if (third_rsp) state_d = DONE;
            DONE:  if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // in_ready is forced low while rst is held, not just after it is released.
    always_comb begin
        in_ready     = (state_q == IDLE) && !rst;
        sm_req_valid = (state_q == ISSUE);
        out_valid    = (state_q == DONE);
        sm_op_a      = '0;
        sm_op_b      = '0;
        if (sm_req_valid) begin
            case (req_cnt_q)
                2'(SLOT_LO): begin
                    sm_op_a = a_q[H-1:0];
                    sm_op_b = b_q[H-1:0];
                end
                2'(SLOT_MID): begin
                    sm_op_a = a_q[H-1:0] ^ a_q[N-1:H];
                    sm_op_b = b_q[H-1:0] ^ b_q[N-1:H];
                end
                default: begin
                    sm_op_a = a_q[N-1:H];
                    sm_op_b = b_q[N-1:H];
                end
            endcase
        end
    end

    always_comb begin
        a_d       = a_q;
        b_d       = b_q;
        req_cnt_d = req_cnt_q;
        if (accept) begin
            a_d       = a_in;
            b_d       = b_in;
            req_cnt_d = '0;
        end else if (req_hs) begin
            req_cnt_d = req_cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q       <= '0;
            b_q       <= '0;
            req_cnt_q <= '0;
        end else begin
            a_q       <= a_d;
            b_q       <= b_d;
            req_cnt_q <= req_cnt_d;
        end
    end

    ka_term_collector #(.N(N)) u_collector (
        .clk       (clk),
        .rst       (rst),
        .clr       (accept),
        .cap_en    (cap_en),
        .rsp_valid (sm_rsp_valid),
        .rsp_data  (sm_rsp_data),
        .third_rsp (third_rsp),
        .term_lo   (term_lo),
        .term_mid  (term_mid),
        .term_hi   (term_hi)
`ifdef KA_MERGE_OUT_EN
        ,
        .product_out (product_out)
`endif
    );

`ifndef SYNTHESIS
    // A response with no outstanding request means the shared multiplier lost sync.
    a_no_stray_rsp: assert property (@(posedge clk) disable iff (rst) sm_rsp_valid |-> cap_en);
`endif

endmodule

// File: tb/tb_ka_split_issue_32bit.sv
// Directed plus randomized bench for ka_split_issue_32bit with a behavioural half multiplier.
module tb_ka_split_issue_32bit;

    localparam int N = 32;
    localparam int H = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   a_in, b_in;
    logic           sm_req_valid;
    logic           sm_req_ready;
    logic [H-1:0]   sm_op_a, sm_op_b;
    logic           sm_rsp_valid;
    logic [N-2:0]   sm_rsp_data;
    logic           out_valid;
    logic           out_ready;
    logic [N-2:0]   term_lo, term_mid, term_hi;
`ifdef KA_MERGE_OUT_EN
    logic [2*N-2:0] product_out;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lat = 1;
    int stall_n = 0;
    int req_idx = 0;
    int stall_cnt = 0;
    logic [31:0] cur_a, cur_b;
    logic [31:0] held_ops;

    typedef struct {
        int          due;
        logic [30:0] data;
    } rsp_t;
    rsp_t rq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ka_split_issue_32bit dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .a_in         (a_in),
        .b_in         (b_in),
        .sm_req_valid (sm_req_valid),
        .sm_req_ready (sm_req_ready),
        .sm_op_a      (sm_op_a),
        .sm_op_b      (sm_op_b),
        .sm_rsp_valid (sm_rsp_valid),
        .sm_rsp_data  (sm_rsp_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .term_lo      (term_lo),
        .term_mid     (term_mid),
        .term_hi      (term_hi)
`ifdef KA_MERGE_OUT_EN
        ,
        .product_out  (product_out)
`endif
    );

    function automatic logic [63:0] clmul(input logic [31:0] x, input logic [31:0] y);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 32; i++)
            if (y[i]) r = r ^ (64'(x) << i);
        return r;
    endfunction

    function automatic logic [31:0] exp_ops(input int idx, input logic [31:0] a, input logic [31:0] b);
        case (idx)
            0:       return {a[15:0], b[15:0]};
            1:       return {a[15:0] ^ a[31:16], b[15:0] ^ b[31:16]};
            default: return {a[31:16], b[31:16]};
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Behavioural shared half multiplier: fixed latency lat, optional stall of stall_n cycles per request.
    always @(negedge clk) begin
        logic [63:0] p;
        #1;
        if (rst) begin
            rq.delete();
            sm_rsp_valid = 1'b0;
            sm_rsp_data  = '0;
            sm_req_ready = 1'b1;
            stall_cnt    = 0;
        end else begin
            if (in_valid && in_ready) req_idx = 0;
            sm_req_ready = 1'b1;
            if (sm_req_valid) begin
                if (stall_cnt < stall_n) begin
                    sm_req_ready = 1'b0;
                    if (stall_cnt == 0) held_ops = {sm_op_a, sm_op_b};
                    else check("op_stable", {sm_op_a, sm_op_b}, held_ops);
                    stall_cnt++;
                end else begin
                    if (stall_n > 0) check("op_stable", {sm_op_a, sm_op_b}, held_ops);
                    stall_cnt = 0;
                    check("extra_req", 64'(req_idx > 2), 0);
                    check("op_order", {sm_op_a, sm_op_b}, exp_ops(req_idx, cur_a, cur_b));
                    p = clmul({16'h0, sm_op_a}, {16'h0, sm_op_b});
                    rq.push_back('{due: cyc + lat, data: p[30:0]});
                    req_idx++;
                end
            end
            sm_rsp_valid = 1'b0;
            if (rq.size() > 0 && rq[0].due == cyc) begin
                sm_rsp_valid = 1'b1;
                sm_rsp_data  = rq[0].data;
                void'(rq.pop_front());
            end
        end
    end

    // Starts and ends on a negedge with the DUT idle.
    task automatic run_txn(input logic [31:0] a, input logic [31:0] b, input int l,
                           input int st, input int hold, input bit chk_lat);
        logic [63:0] lo, mid, hi, full, asm;
        int n;
        lat = l; stall_n = st; cur_a = a; cur_b = b;
        in_valid = 1'b1; a_in = a; b_in = b; out_ready = (hold == 0);
        check("in_ready_idle", 64'(in_ready), 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        check("in_ready_busy", 64'(in_ready), 0);
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("out_valid", 64'(out_valid), 1);
        if (chk_lat) check("latency", 64'(n), 64'(4 + l));
        lo   = clmul({16'h0, a[15:0]}, {16'h0, b[15:0]});
        hi   = clmul({16'h0, a[31:16]}, {16'h0, b[31:16]});
        mid  = clmul({16'h0, a[15:0] ^ a[31:16]}, {16'h0, b[15:0] ^ b[31:16]}) ^ lo ^ hi;
        full = clmul(a, b);
        check("term_lo", 64'(term_lo), lo);
        check("term_mid", 64'(term_mid), mid);
        check("term_hi", 64'(term_hi), hi);
        asm = 64'(term_lo) ^ (64'(term_mid) << H) ^ (64'(term_hi) << N);
        check("assembled", asm, full);
`ifdef KA_MERGE_OUT_EN
        check("product_out", 64'(product_out), full);
`endif
        for (int h = 0; h < hold; h++) begin
            check("hold_valid", 64'(out_valid), 1);
            check("hold_in_ready", 64'(in_ready), 0);
            check("hold_terms", {1'b0, term_lo, term_hi[31-H-1:0]}, {1'b0, lo[30:0], hi[14:0]});
            check("hold_mid", 64'(term_mid), mid);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("out_drop", 64'(out_valid), 0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        rst = 1'b1; in_valid = 1'b0; a_in = '0; b_in = '0; out_ready = 1'b1;
        sm_req_ready = 1'b1; sm_rsp_valid = 1'b0; sm_rsp_data = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 0);
        check("rst_out_valid", 64'(out_valid), 0);
        check("rst_req_valid", 64'(sm_req_valid), 0);
        check("rst_terms", {term_lo, term_mid}, 0);
        rst = 1'b0;
        @(negedge clk);

        run_txn(32'h0000_0003, 32'h0000_0003, 1, 0, 0, 1'b1);
        run_txn(32'h0001_0001, 32'h0001_0001, 1, 0, 0, 1'b1);
        run_txn(32'hFFFF_FFFF, 32'h0000_0001, 2, 0, 0, 1'b1);
        run_txn(32'h1234_5678, 32'h9ABC_DEF0, 4, 0, 0, 1'b1);
        run_txn(32'h1234_5678, 32'h9ABC_DEF0, 4, 3, 5, 1'b0);
        for (int k = 0; k < 10; k++) begin
            ra = $urandom;
            rb = $urandom;
            run_txn(ra, rb, int'($urandom_range(1, 4)), int'($urandom_range(0, 2)),
                    int'($urandom_range(0, 2)), 1'b0);
        end

        // Abort a transaction while it waits on responses.
        ra = $urandom | 32'h0001_0001;
        lat = 6; stall_n = 0; cur_a = ra; cur_b = ra;
        in_valid = 1'b1; a_in = ra; b_in = ra;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("wait_no_req", 64'(sm_req_valid), 0);
        #2 rst = 1'b1;
        #1;
        check("arst_out_valid", 64'(out_valid), 0);
        check("arst_in_ready", 64'(in_ready), 0);
        check("arst_terms", {1'b0, term_lo, term_hi[31-H-1:0]}, 0);
        check("arst_mid", 64'(term_mid), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_txn(32'h0001_0000, 32'h0001_0000, 1, 0, 0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
